sram_req_arbiter: RTL

//  Shares one class-SRAM memory port (req/addr_ok/data_ok) between the IF-stage instruction requester and the MEM-stage data requester.

---
 rtl/sram_req_arbiter_pkg.sv | 13 +
 rtl/sram_ret_fifo.sv | 50 +++++
 rtl/sram_req_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// Shared encodings for the SRAM request arbiter: source tags and grant FSM states.
package sram_req_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sram_ret_fifo.sv
// In-order source tag FIFO: one bit per accepted-but-unreturned request.
module sram_ret_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_push,
  input  logic i_src,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_src;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-style port between IF (inst) and MEM (data) requesters:
// fixed-priority grant held until addr_ok, responses routed by acceptance order.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUT   = 2,
  parameter bit ASSERT_ON = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t r_state, w_state_nxt;
  logic       w_sel, w_sel_req, w_accept, w_pop;
  logic       w_full, w_empty, w_head;

  always_comb begin
    w_sel     = SRC_INST;
    w_sel_req = 1'b0;
    case (r_state)
      ST_LOCK_INST: begin w_sel = SRC_INST; w_sel_req = inst_req; end
      ST_LOCK_DATA: begin w_sel = SRC_DATA; w_sel_req = data_req; end
      default: begin
        if (data_req)      begin w_sel = SRC_DATA; w_sel_req = 1'b1; end
        else if (inst_req) begin w_sel = SRC_INST; w_sel_req = 1'b1; end
      end
    endcase
  end

  // resetn gating keeps every handshake low while reset is asserted, before state clears.
  assign mem_req  = resetn & w_sel_req & ~w_full;
  assign w_accept = mem_req & mem_addr_ok;
  assign w_pop    = resetn & mem_data_ok & ~w_empty;

  assign inst_addr_ok = w_accept & (w_sel == SRC_INST);
  assign data_addr_ok = w_accept & (w_sel == SRC_DATA);
  assign inst_data_ok = w_pop & (w_head == SRC_INST);
  assign data_data_ok = w_pop & (w_head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign mem_wr    = (w_sel == SRC_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (w_sel == SRC_DATA) ? data_size  : inst_size;
  assign mem_wstrb = (w_sel == SRC_DATA) ? data_wstrb : inst_wstrb;
  assign mem_addr  = (w_sel == SRC_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (w_sel == SRC_DATA) ? data_wdata : inst_wdata;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:
        if (mem_req && !mem_addr_ok)
          w_state_nxt = (w_sel == SRC_DATA) ? ST_LOCK_DATA : ST_LOCK_INST;
      ST_LOCK_INST, ST_LOCK_DATA:
        if (w_accept) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  sram_ret_fifo #(.DEPTH(MAX_OUT)) u_ret_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_accept),
    .i_src   (w_sel),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

`ifndef SYNTHESIS
  // A response with nothing outstanding is dropped; flag it in simulation.
  always_ff @(posedge clk) begin
    if (ASSERT_ON && resetn && mem_data_ok)
      assert (!w_empty) else $error("sram_req_arbiter: mem_data_ok with no outstanding request");
  end
`endif

endmodule
